// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-port RAM16K arbiter.
//   ADDR_W / DATA_W : RAM16K word address and data widths
//   arb_state_t     : arbiter ownership state
//   port_idx_t      : index of a requesting port (0 or 1)
package ram_arb_pkg;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection for the RAM16K arbiter.
//   req       : per-port request
//   state     : current ownership state
//   last      : port granted most recently
//   burst_cnt : transfers in the current ownership
//   gnt       : one-hot grant (all zero when nobody requests)
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic [1:0]         req,
    input  arb_state_t         state,
    input  port_idx_t          last,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic [1:0]         gnt
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    logic [1:0] idle_gnt;

    always_comb begin
        // Round-robin: on contention the port that was not served last wins.
        unique case (req)
            2'b01:   idle_gnt = 2'b01;
            2'b10:   idle_gnt = 2'b10;
            2'b11:   idle_gnt = last ? 2'b01 : 2'b10;
            default: idle_gnt = 2'b00;
        endcase
    end

    always_comb begin
        gnt = idle_gnt;
        unique case (state)
            OWN0: begin
                if (req[0]) begin
                    gnt = (burst_cnt == MAX_B && req[1]) ? 2'b10 : 2'b01;
                end
            end
            OWN1: begin
                if (req[1]) begin
                    gnt = (burst_cnt == MAX_B && req[0]) ? 2'b01 : 2'b10;
                end
            end
            default: gnt = idle_gnt;
        endcase
    end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter sharing one RAM16K between two requesters.
// Round-robin with optional locked bursts bounded by MAX_BURST.
//   clk, reset            : clock, asynchronous active-high reset
//   pN_req/we/lock        : request, write enable, keep-ownership hint
//   pN_addr/wdata         : word address and write data
//   pN_gnt                : combinational grant
//   pN_rvalid/rdata       : registered read return, one cycle after a read
//   ram_address/in/load   : driven to RAM16K from the winning port
//   ram_out               : RAM16K combinational read data
module ram16k_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    arb_state_t         state_q, state_d;
    port_idx_t          last_q, last_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               p0_rvalid_q, p0_rvalid_d;
    logic               p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0]  p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]  p1_rdata_q, p1_rdata_d;

    logic [1:0] req;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic [1:0] xfer;
    port_idx_t  win;
    logic       win_lock;
    logic       win_we;
    logic       same_owner;

    assign req = {p1_req, p0_req};

    ram_arb_pick #(
        .MAX_BURST(MAX_BURST)
    ) u_pick (
        .req      (req),
        .state    (state_q),
        .last     (last_q),
        .burst_cnt(burst_cnt_q),
        .gnt      (gnt_raw)
    );

    // Grants are held low for the whole reset assertion.
    assign gnt    = reset ? 2'b00 : gnt_raw;
    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];
    assign xfer   = req & gnt;
    assign win    = xfer[1];

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    always_comb begin
        ram_address = '0;
        ram_in      = '0;
        ram_load    = 1'b0;
        win_lock    = 1'b0;
        win_we      = 1'b0;
        if (xfer[0]) begin
            ram_address = p0_addr;
            ram_in      = p0_wdata;
            ram_load    = p0_we;
            win_lock    = p0_lock;
            win_we      = p0_we;
        end else if (xfer[1]) begin
            ram_address = p1_addr;
            ram_in      = p1_wdata;
            ram_load    = p1_we;
            win_lock    = p1_lock;
            win_we      = p1_we;
        end
    end

    assign same_owner = (state_q == OWN0 && !win) || (state_q == OWN1 && win);

    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        burst_cnt_d = '0;
        p0_rvalid_d = xfer[0] && !p0_we;
        p1_rvalid_d = xfer[1] && !p1_we;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        if (p0_rvalid_d) p0_rdata_d = ram_out;
        if (p1_rvalid_d) p1_rdata_d = ram_out;
        if (|xfer) begin
            last_d = win;
            if (win_lock) begin
                state_d = win ? OWN1 : OWN0;
                if (!same_owner) begin
                    burst_cnt_d = BURST_W'(1);
                end else if (burst_cnt_q >= MAX_B) begin
                    burst_cnt_d = MAX_B;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

endmodule
